// File: rtl/ctrl_msg_switch_pkg.sv
// Shared field positions and helpers for the control-message switch.
// Word layout: dest [63:56], src [55:48], header [47:40].
package ctrl_msg_switch_pkg;

    localparam int unsigned CTRL_DEST_MSB = 63;
    localparam int unsigned CTRL_DEST_LSB = 56;
    localparam int unsigned CTRL_SRC_MSB  = 55;
    localparam int unsigned CTRL_SRC_LSB  = 48;
    localparam int unsigned CTRL_MSG_MSB  = 47;

    localparam logic [7:0] BROADCAST_ID = 8'hff;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_msg_switch_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// The rotation pointer is owned by the caller.
module rr_arbiter
    import ctrl_msg_switch_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
        int unsigned s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = wrap_add(ptr, k);
            if (en && !any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_msg_switch.sv
// Root <-> children control-message switch: broadcast/unicast fan-out downstream,
// round-robin merge with source stamping upstream.
module ctrl_msg_switch
    import ctrl_msg_switch_pkg::*;
#(
    parameter int unsigned CTRL_FIFO_WIDTH = 64,
    parameter int unsigned NUM_CHILDREN    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [CTRL_FIFO_WIDTH-1:0]            data_from_root,
    input  logic                                  valid_from_root,
    output logic                                  ready_from_root,
    output logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] data_to_children,
    output logic [NUM_CHILDREN-1:0]               valid_to_children,
    input  logic [NUM_CHILDREN-1:0]               ready_to_children,
    input  logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] data_from_children,
    input  logic [NUM_CHILDREN-1:0]               valid_from_children,
    output logic [NUM_CHILDREN-1:0]               ready_from_children,
    output logic [CTRL_FIFO_WIDTH-1:0]            data_to_root,
    output logic                                  valid_to_root,
    input  logic                                  ready_to_root,
    output logic                                  busy,
    output logic                                  drop_error
);

    localparam int unsigned IW = idx_width(NUM_CHILDREN);

    logic [NUM_CHILDREN-1:0]    pending_q, pending_d;
    logic [CTRL_FIFO_WIDTH-1:0] hold_q, hold_d;
    logic                       drop_error_q, drop_error_d;
    logic                       out_valid_q, out_valid_d;
    logic [CTRL_FIFO_WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]              ptr_q, ptr_d;

    logic [7:0]                 dest;
    logic                       can_load;
    logic [NUM_CHILDREN-1:0]    grant;
    logic [IW-1:0]              grant_idx;
    logic                       grant_any;
    logic [CTRL_FIFO_WIDTH-1:0] granted_word;

    assign dest         = data_from_root[CTRL_DEST_MSB:CTRL_DEST_LSB];
    assign can_load     = !out_valid_q || ready_to_root;
    assign granted_word = data_from_children[int'(grant_idx)*CTRL_FIFO_WIDTH +: CTRL_FIFO_WIDTH];

    rr_arbiter #(
        .N  (NUM_CHILDREN),
        .IW (IW)
    ) u_arb (
        .req       (valid_from_children),
        .en        (can_load),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Downstream: a new word is only accepted once every addressed child has taken the last one.
    always_comb begin
        pending_d    = pending_q & ~ready_to_children;
        hold_d       = hold_q;
        drop_error_d = drop_error_q;
        if (valid_from_root && ready_from_root) begin
            hold_d = data_from_root;
            if (dest == BROADCAST_ID) begin
                pending_d = '1;
            end else if (32'(dest) < NUM_CHILDREN) begin
                pending_d = NUM_CHILDREN'(1) << dest;
            end else begin
                drop_error_d = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        if (grant_any) begin
            out_data_d = granted_word;
            out_data_d[CTRL_SRC_MSB:CTRL_SRC_LSB] = 8'(grant_idx);
            out_valid_d = 1'b1;
            ptr_d = (32'(grant_idx) == NUM_CHILDREN - 1) ? '0 : grant_idx + 1'b1;
        end else if (can_load && ready_to_root) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= '0;
            hold_q       <= '0;
            drop_error_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            ptr_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            hold_q       <= hold_d;
            drop_error_q <= drop_error_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            ptr_q        <= ptr_d;
        end
    end

    assign ready_from_root     = (pending_q == '0);
    assign valid_to_children   = pending_q;
    assign data_to_children    = {NUM_CHILDREN{hold_q}};
    assign ready_from_children = grant;
    assign valid_to_root       = out_valid_q;
    assign data_to_root        = out_data_q;
    assign busy                = (pending_q != '0) || out_valid_q;
    assign drop_error          = drop_error_q;

endmodule

// File: tb/tb_ctrl_msg_switch.sv
// Self-checking bench for ctrl_msg_switch: directed vectors, corner sequences,
// and randomized traffic against a behavioural model.
module tb_ctrl_msg_switch;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [W-1:0]     data_from_root;
    logic             valid_from_root;
    logic             ready_from_root;
    logic [N*W-1:0]   data_to_children;
    logic [N-1:0]     valid_to_children;
    logic [N-1:0]     ready_to_children;
    logic [N*W-1:0]   data_from_children;
    logic [N-1:0]     valid_from_children;
    logic [N-1:0]     ready_from_children;
    logic [W-1:0]     data_to_root;
    logic             valid_to_root;
    logic             ready_to_root;
    logic             busy;
    logic             drop_error;

    int n_total = 0;
    int n_pass  = 0;

    ctrl_msg_switch #(
        .CTRL_FIFO_WIDTH (W),
        .NUM_CHILDREN    (N)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .data_from_root      (data_from_root),
        .valid_from_root     (valid_from_root),
        .ready_from_root     (ready_from_root),
        .data_to_children    (data_to_children),
        .valid_to_children   (valid_to_children),
        .ready_to_children   (ready_to_children),
        .data_from_children  (data_from_children),
        .valid_from_children (valid_from_children),
        .ready_from_children (ready_from_children),
        .data_to_root        (data_to_root),
        .valid_to_root       (valid_to_root),
        .ready_to_root       (ready_to_root),
        .busy                (busy),
        .drop_error          (drop_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] rdy;
        logic [N-1:0] exp_vld;
        logic         exp_rfr;
        logic         exp_busy;
    } bvec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] mkw(input logic [7:0] d, input logic [7:0] s,
                                         input logic [7:0] h, input logic [39:0] p);
        return {d, s, h, p};
    endfunction

    function automatic logic [W-1:0] stamp(input logic [W-1:0] w, input int src);
        logic [W-1:0] r;
        r = w;
        r[55:48] = 8'(src);
        return r;
    endfunction

    // Requester closest (cyclic distance) at or after p wins; -1 when none.
    function automatic int pick(input logic [N-1:0] req, input int p);
        int best, bestd, d;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i - p + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    bvec_t        bv[5];
    logic [W-1:0] bw, w1, w2;
    logic [W-1:0] cw[N];
    int           mp, g;

    // Randomized-phase model state
    logic [N-1:0] m_pend;
    logic [W-1:0] m_hold, m_od;
    logic         m_drop, m_ov;
    int           m_ptr;

    initial begin
        bv[0] = '{rdy: 4'b1000, exp_vld: 4'b1111, exp_rfr: 1'b0, exp_busy: 1'b1};
        bv[1] = '{rdy: 4'b0001, exp_vld: 4'b0111, exp_rfr: 1'b0, exp_busy: 1'b1};
        bv[2] = '{rdy: 4'b0100, exp_vld: 4'b0110, exp_rfr: 1'b0, exp_busy: 1'b1};
        bv[3] = '{rdy: 4'b0010, exp_vld: 4'b0010, exp_rfr: 1'b0, exp_busy: 1'b1};
        bv[4] = '{rdy: 4'b0000, exp_vld: 4'b0000, exp_rfr: 1'b1, exp_busy: 1'b0};

        reset_n = 1'b0;
        data_from_root = '0;
        valid_from_root = 1'b0;
        ready_to_children = '0;
        data_from_children = '0;
        valid_from_children = '0;
        ready_to_root = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready_from_root", 64'(ready_from_root), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid_to_children", 64'(valid_to_children), 64'd0);
        check("rst_valid_to_root", 64'(valid_to_root), 64'd0);
        check("rst_drop_error", 64'(drop_error), 64'd0);
        reset_n = 1'b1;
        tick();

        // Broadcast, children take it in order 3,0,2,1
        bw = mkw(8'hff, 8'hff, 8'h01, 40'h12_3456_7890);
        data_from_root = bw;
        valid_from_root = 1'b1;
        tick();
        valid_from_root = 1'b0;
        data_from_root = '0;
        for (int i = 0; i < N; i++) check($sformatf("bc_data_slice%0d", i), data_to_children[i*W +: W], bw);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bc_valid_v%0d", i), 64'(valid_to_children), 64'(bv[i].exp_vld));
            check($sformatf("bc_rfr_v%0d", i), 64'(ready_from_root), 64'(bv[i].exp_rfr));
            check($sformatf("bc_busy_v%0d", i), 64'(busy), 64'(bv[i].exp_busy));
            ready_to_children = bv[i].rdy;
            tick();
        end
        ready_to_children = '0;

        // Unicast to child 2, then an illegal destination
        data_from_root = mkw(8'h02, 8'hff, 8'h02, 40'hab_cdef_0123);
        valid_from_root = 1'b1;
        tick();
        valid_from_root = 1'b0;
        check("uc_valid", 64'(valid_to_children), 64'b0100);
        check("uc_rfr_low", 64'(ready_from_root), 64'd0);
        ready_to_children = 4'b0100;
        tick();
        ready_to_children = '0;
        check("uc_done_valid", 64'(valid_to_children), 64'd0);
        check("uc_done_rfr", 64'(ready_from_root), 64'd1);
        data_from_root = mkw(8'h07, 8'hff, 8'h02, 40'h0);
        valid_from_root = 1'b1;
        tick();
        valid_from_root = 1'b0;
        check("bad_dest_valid", 64'(valid_to_children), 64'd0);
        check("bad_dest_drop", 64'(drop_error), 64'd1);
        check("bad_dest_busy", 64'(busy), 64'd0);
        check("bad_dest_rfr", 64'(ready_from_root), 64'd1);

        // All children request with the root always ready
        for (int i = 0; i < N; i++) begin
            cw[i] = mkw(8'h00, 8'hee, 8'h30, 40'(64'h11_1111_1111 * (i + 1)));
            data_from_children[i*W +: W] = cw[i];
        end
        valid_from_children = '1;
        ready_to_root = 1'b1;
        for (int k = 0; k < N; k++) begin
            #1;
            check($sformatf("all_grant%0d", k), 64'(ready_from_children), 64'(1 << k));
            tick();
            valid_from_children[k] = 1'b0;
            check($sformatf("all_vtr%0d", k), 64'(valid_to_root), 64'd1);
            check($sformatf("all_data%0d", k), data_to_root, stamp(cw[k], k));
        end
        tick();
        check("all_drained", 64'(valid_to_root), 64'd0);
        valid_from_children = '1;
        #1;
        check("ptr_wrapped", 64'(ready_from_children), 64'b0001);
        valid_from_children = '0;
        tick();

        // Back-pressure while child 1 keeps requesting
        ready_to_root = 1'b0;
        w1 = mkw(8'h00, 8'h00, 8'h30, 40'haa_aaaa_0001);
        w2 = mkw(8'h00, 8'h00, 8'h31, 40'hbb_bbbb_0002);
        data_from_children[1*W +: W] = w1;
        valid_from_children = 4'b0010;
        tick();
        data_from_children[1*W +: W] = w2;
        check("bp_first_valid", 64'(valid_to_root), 64'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_no_grant%0d", c), 64'(ready_from_children), 64'd0);
            check($sformatf("bp_hold%0d", c), data_to_root, stamp(w1, 1));
            tick();
        end
        ready_to_root = 1'b1;
        #1;
        check("bp_release_grant", 64'(ready_from_children), 64'b0010);
        tick();
        valid_from_children = '0;
        check("bp_second_word", data_to_root, stamp(w2, 1));
        check("bp_second_valid", 64'(valid_to_root), 64'd1);
        tick();
        check("bp_no_dup", 64'(valid_to_root), 64'd0);

        // Children 0 and 2 stream continuously; child 1 joins midway
        mp = 2;
        valid_from_children = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) valid_from_children[1] = 1'b1;
            #1;
            g = pick(valid_from_children, mp);
            check($sformatf("alt_grant%0d", k), 64'(ready_from_children), 64'(1 << g));
            tick();
            check($sformatf("alt_src%0d", k), 64'(data_to_root[55:48]), 64'(g));
            mp = (g + 1) % N;
            if (g == 1) valid_from_children[1] = 1'b0;
        end
        valid_from_children = '0;
        tick();

        // Reset in the middle of a broadcast
        data_from_root = bw;
        valid_from_root = 1'b1;
        tick();
        valid_from_root = 1'b0;
        ready_to_children = 4'b0101;
        tick();
        ready_to_children = '0;
        check("mid_rst_pending", 64'(valid_to_children), 64'b1010);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_async_valid", 64'(valid_to_children), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_rfr", 64'(ready_from_root), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_drop", 64'(drop_error), 64'd0);

        // Randomized traffic against the model, from a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_pend = '0; m_hold = '0; m_drop = 1'b0; m_ov = 1'b0; m_od = '0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int r, gg;
            logic [7:0] d;
            logic cl;
            r = $urandom_range(0, 9);
            d = (r < 4) ? 8'(r) : (r < 7) ? 8'hff : 8'($urandom_range(4, 254));
            data_from_root = mkw(d, 8'($urandom), 8'($urandom), {8'($urandom), 32'($urandom)});
            valid_from_root = ($urandom_range(0, 2) != 0);
            ready_to_children = 4'($urandom);
            for (int i = 0; i < N; i++)
                data_from_children[i*W +: W] = {32'($urandom), 32'($urandom)};
            valid_from_children = 4'($urandom);
            ready_to_root = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_valid_to_children", 64'(valid_to_children), 64'(m_pend));
            check("rnd_ready_from_root", 64'(ready_from_root), 64'(m_pend == 0));
            check("rnd_data_to_children", data_to_children[(cyc % N)*W +: W], m_hold);
            check("rnd_valid_to_root", 64'(valid_to_root), 64'(m_ov));
            if (m_ov) check("rnd_data_to_root", data_to_root, m_od);
            check("rnd_busy", 64'(busy), 64'((m_pend != 0) || m_ov));
            check("rnd_drop_error", 64'(drop_error), 64'(m_drop));
            cl = !m_ov || ready_to_root;
            gg = cl ? pick(valid_from_children, m_ptr) : -1;
            check("rnd_ready_from_children", 64'(ready_from_children), (gg >= 0) ? 64'(1 << gg) : 64'd0);

            if (valid_from_root && m_pend == 0) begin
                m_hold = data_from_root;
                if (d == 8'hff) m_pend = '1;
                else if (int'(d) < N) m_pend = 4'(1 << d);
                else m_drop = 1'b1;
            end else begin
                m_pend = m_pend & ~ready_to_children;
            end
            if (gg >= 0) begin
                m_od = stamp(data_from_children[gg*W +: W], gg);
                m_ov = 1'b1;
                m_ptr = (gg + 1) % N;
            end else if (cl && ready_to_root) begin
                m_ov = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
